// File: rtl/l1_trig_pkg.sv
// Shared types and defaults for the L1 accept controller.
// Holds the controller state enum and the readout event record.
package l1_trig_pkg;

    localparam int L1_SCORE_W   = 32;
    localparam int L1_BCID_W    = 12;
    localparam int L1_ORBIT_LEN = 3564;

    typedef enum logic {
        IDLE,
        DEAD
    } l1a_state_t;

    typedef struct packed {
        logic [L1_BCID_W-1:0]  bcid;
        logic [L1_SCORE_W-1:0] score;
    } l1a_event_t;

endpackage

// File: rtl/l1a_readout_fifo.sv
// First-word-fall-through FIFO of accepted events.
// Entry 0 is the head register; a pop shifts all entries down.
module l1a_readout_fifo
    import l1_trig_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  l1a_event_t               din,
    output l1a_event_t               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CW = $clog2(DEPTH) + 1;

    l1a_event_t     mem [DEPTH];
    logic           pop_ok;
    logic           push_ok;
    logic [CW-1:0]  wr_idx;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign wr_idx  = count - CW'(pop_ok);
    assign head    = mem[0];

    // Shift on pop, write the incoming event just past the surviving entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_ok && wr_idx == CW'(i)) begin
                    mem[i] <= din;
                end else if (pop_ok && i < DEPTH - 1) begin
                    mem[i] <= mem[(i < DEPTH - 1) ? i + 1 : i];
                end
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/l1a_accept_ctrl.sv
// L1 accept controller: BCID, prescale, deadtime and readout buffer.
// Optional macro L1A_FORCE_EN adds a prescale-bypassing force_trig input.
module l1a_accept_ctrl
    import l1_trig_pkg::*;
#(
    parameter int SCORE_W    = L1_SCORE_W,
    parameter int BCID_W     = L1_BCID_W,
    parameter int ORBIT_LEN  = L1_ORBIT_LEN,
    parameter int FIFO_DEPTH = 8,
    parameter int DEADTIME   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bx_strobe,
    input  logic               orbit_sync,
    input  logic               trigger_in,
    input  logic [SCORE_W-1:0] score_in,
    input  logic [7:0]         prescale,
`ifdef L1A_FORCE_EN
    input  logic               force_trig,
`endif
    output logic               l1a,
    output logic               busy,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [SCORE_W-1:0] rd_score,
    output logic [BCID_W-1:0]  rd_bcid,
    output logic [BCID_W-1:0]  bcid,
    output logic [15:0]        drop_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;

    l1a_state_t     state;
    l1a_state_t     state_n;
    logic [7:0]     pscnt;
    logic [7:0]     pscnt_n;
    logic [DW-1:0]  deadcnt;
    logic [DW-1:0]  dead_n;
    logic           cand;
    logic           frc;
    logic           accept;
    logic           drop;
    logic           pop;
    logic           full;
    logic           empty;
    logic           full_now;
    logic           full_n;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_n;
    l1a_event_t     ev;
    l1a_event_t     head;

`ifdef L1A_FORCE_EN
    assign frc = bx_strobe & force_trig;
`else
    assign frc = 1'b0;
`endif

    assign cand     = bx_strobe & trigger_in;
    assign rd_valid = ~empty;
    assign pop      = rd_valid & rd_ready;
    assign full_now = full & ~pop;
    assign count_n  = count + CW'(accept) - CW'(pop);
    assign full_n   = (count_n == CW'(FIFO_DEPTH));
    assign ev.bcid  = L1_BCID_W'(bcid);
    assign ev.score = L1_SCORE_W'(score_in);
    assign rd_score = SCORE_W'(head.score);
    assign rd_bcid  = BCID_W'(head.bcid);

    l1a_readout_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .din   (ev),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Accept/drop decision and next state for prescale and deadtime.
    always_comb begin
        state_n = state;
        pscnt_n = pscnt;
        dead_n  = deadcnt;
        accept  = 1'b0;
        drop    = 1'b0;
        unique case (state)
            IDLE: begin
                if (cand | frc) begin
                    if (full_now) begin
                        drop = 1'b1;
                    end else if (frc) begin
                        accept = 1'b1;
                    end else if (pscnt >= prescale) begin
                        accept  = 1'b1;
                        pscnt_n = '0;
                    end else begin
                        pscnt_n = pscnt + 8'd1;
                    end
                end
                if (accept && DEADTIME > 0) begin
                    state_n = DEAD;
                    dead_n  = DW'(DEADTIME);
                end
            end
            DEAD: begin
                if (bx_strobe) begin
                    drop   = cand | frc;
                    dead_n = deadcnt - DW'(1);
                    if (deadcnt == DW'(1)) begin
                        state_n = IDLE;
                    end
                end
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pscnt   <= '0;
            deadcnt <= '0;
        end else begin
            state   <= state_n;
            pscnt   <= pscnt_n;
            deadcnt <= dead_n;
        end
    end

    // Registered outputs: accept pulse, busy, BX counter, drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            l1a      <= 1'b0;
            busy     <= 1'b0;
            bcid     <= '0;
            drop_cnt <= '0;
        end else begin
            l1a  <= accept;
            busy <= (state_n == DEAD) | full_n;
            if (bx_strobe) begin
                if (orbit_sync || bcid == BCID_W'(ORBIT_LEN - 1)) begin
                    bcid <= '0;
                end else begin
                    bcid <= bcid + BCID_W'(1);
                end
            end
            if (drop && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_l1a_accept_ctrl.sv
// Bench for l1a_accept_ctrl: one instance with deadtime 4, one without.
// Readout events are checked by per-instance scoreboard monitors.
module tb_l1a_accept_ctrl;
    import l1_trig_pkg::*;

    logic        clk = 0;
    logic        rst = 1;
    logic        bx_strobe = 0;
    logic        orbit_sync = 0;
    logic        trig4 = 0;
    logic        trig0 = 0;
    logic        rr4 = 0;
    logic        rr0 = 0;
    logic [31:0] score = 0;
    logic [7:0]  prescale = 0;

    logic        l1a4, busy4, rv4, l1a0, busy0, rv0;
    logic [31:0] rs4, rs0;
    logic [11:0] rb4, rb0, bcid4, bcid0;
    logic [15:0] dc4, dc0;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cur_bcid = 0;
    l1a_event_t  q4[$];
    l1a_event_t  q0[$];
    l1a_event_t  e4;
    l1a_event_t  e0;

    always #5 clk = ~clk;

    l1a_accept_ctrl #(.DEADTIME(4)) u4 (
        .clk        (clk),
        .rst        (rst),
        .bx_strobe  (bx_strobe),
        .orbit_sync (orbit_sync),
        .trigger_in (trig4),
        .score_in   (score),
        .prescale   (prescale),
`ifdef L1A_FORCE_EN
        .force_trig (1'b0),
`endif
        .l1a        (l1a4),
        .busy       (busy4),
        .rd_valid   (rv4),
        .rd_ready   (rr4),
        .rd_score   (rs4),
        .rd_bcid    (rb4),
        .bcid       (bcid4),
        .drop_cnt   (dc4)
    );

    l1a_accept_ctrl #(.DEADTIME(0)) u0 (
        .clk        (clk),
        .rst        (rst),
        .bx_strobe  (bx_strobe),
        .orbit_sync (orbit_sync),
        .trigger_in (trig0),
        .score_in   (score),
        .prescale   (prescale),
`ifdef L1A_FORCE_EN
        .force_trig (1'b0),
`endif
        .l1a        (l1a0),
        .busy       (busy0),
        .rd_valid   (rv0),
        .rd_ready   (rr0),
        .rd_score   (rs0),
        .rd_bcid    (rb0),
        .bcid       (bcid0),
        .drop_cnt   (dc0)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One BX: strobe cycle, then a quiet cycle in which l1a is checked.
    task automatic bx(input logic t4, input logic t0, input logic a4,
                      input logic a0, input logic [31:0] sc,
                      input logic os, input logic pr);
        l1a_event_t e;
        @(posedge clk);
        #1;
        chk("l1a4_off", 32'(l1a4), 32'd0);
        chk("l1a0_off", 32'(l1a0), 32'd0);
        bx_strobe  = 1;
        trig4      = t4;
        trig0      = t0;
        score      = sc;
        orbit_sync = os;
        if (pr) rr0 = 1;
        e.bcid  = 12'(cur_bcid);
        e.score = sc;
        if (a4) q4.push_back(e);
        if (a0) q0.push_back(e);
        @(posedge clk);
        #1;
        bx_strobe  = 0;
        trig4      = 0;
        trig0      = 0;
        orbit_sync = 0;
        if (pr) rr0 = 0;
        cur_bcid = os ? 0 : ((cur_bcid == 3563) ? 0 : cur_bcid + 1);
        @(negedge clk);
        chk("l1a4", 32'(l1a4), 32'(a4));
        chk("l1a0", 32'(l1a0), 32'(a0));
    endtask

    always @(negedge clk) begin
        if (!rst && rv4 && rr4) begin
            n_chk++;
            if (q4.size() == 0) begin
                n_fail++;
                $display("FAIL rd4_extra: got bcid %0d score %0h expected none",
                         rb4, rs4);
            end else begin
                e4 = q4.pop_front();
                if (rb4 !== e4.bcid || rs4 !== e4.score) begin
                    n_fail++;
                    $display("FAIL rd4: got bcid %0d score %0h expected bcid %0d score %0h",
                             rb4, rs4, e4.bcid, e4.score);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && rv0 && rr0) begin
            n_chk++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL rd0_extra: got bcid %0d score %0h expected none",
                         rb0, rs0);
            end else begin
                e0 = q0.pop_front();
                if (rb0 !== e0.bcid || rs0 !== e0.score) begin
                    n_fail++;
                    $display("FAIL rd0: got bcid %0d score %0h expected bcid %0d score %0h",
                             rb0, rs0, e0.bcid, e0.score);
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_l1a",   32'(l1a4),  32'd0);
        chk("rst_busy",  32'(busy4), 32'd0);
        chk("rst_valid", 32'(rv4),   32'd0);
        chk("rst_score", rs4,        32'd0);
        chk("rst_rbcid", 32'(rb4),   32'd0);
        chk("rst_bcid",  32'(bcid4), 32'd0);
        chk("rst_drop",  32'(dc4),   32'd0);
        chk("rst_valid0", 32'(rv0),  32'd0);
        @(posedge clk);
        #1;
        rst = 0;
        rr4 = 1;
        rr0 = 1;

        // Deadtime 4, prescale 0, trigger every BX from BCID 10.
        prescale = 0;
        for (int i = 0; i < 10; i++) bx(0, 0, 0, 0, 0, 0, 0);
        chk("bcid_10", 32'(bcid4), 32'd10);
        for (int b = 10; b < 25; b++) begin
            bx(1, 0, ((b - 10) % 5 == 0), 0, 32'(b * 3), 0, 0);
            if (b == 12) chk("busy4_dead", 32'(busy4), 32'd1);
        end
        chk("drop4_dead", 32'(dc4), 32'd12);
        chk("busy4_idle", 32'(busy4), 32'd0);

        // Orbit sync, then prescale 2 on the no-deadtime instance.
        bx(0, 0, 0, 0, 0, 1, 0);
        chk("orbit_sync0", 32'(bcid0), 32'd0);
        bx(0, 0, 0, 0, 0, 0, 0);
        prescale = 2;
        for (int b = 1; b < 10; b++) bx(0, 1, 0, (b % 3 == 0), 32'(1000 + b), 0, 0);
        chk("drop0_ps", 32'(dc0), 32'd0);

        // Fill the FIFO with readout stalled.
        repeat (2) @(posedge clk);
        #1;
        rr0 = 0;
        prescale = 0;
        for (int i = 0; i < 8; i++) bx(0, 1, 0, 1, 32'(500 + i), 0, 0);
        chk("busy0_full", 32'(busy0), 32'd1);
        chk("valid0_full", 32'(rv0), 32'd1);
        bx(0, 1, 0, 0, 32'd999, 0, 0);
        chk("drop0_full", 32'(dc0), 32'd1);
        bx(0, 1, 0, 1, 32'd600, 0, 1);
        chk("drop0_pushpop", 32'(dc0), 32'd1);
        chk("busy0_pushpop", 32'(busy0), 32'd1);
        @(posedge clk);
        #1;
        rr0 = 1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("valid0_drained", 32'(rv0), 32'd0);
        chk("busy0_drained", 32'(busy0), 32'd0);

        // Signed score extremes pass through untouched.
        bx(0, 1, 0, 1, 32'hFFFF_FF18, 0, 0);
        bx(0, 1, 0, 1, 32'h7FFF_FFFF, 0, 0);
        bx(0, 1, 0, 1, 32'h8000_0000, 0, 0);

        // Orbit sync at BCID 100, then a full orbit to the wrap.
        while (cur_bcid != 100) bx(0, 0, 0, 0, 0, 0, 0);
        chk("bcid_100", 32'(bcid4), 32'd100);
        bx(0, 0, 0, 0, 0, 1, 0);
        chk("orbit_sync4", 32'(bcid4), 32'd0);
        for (int i = 0; i < 3563; i++) bx(0, 0, 0, 0, 0, 0, 0);
        chk("bcid_3563", 32'(bcid0), 32'd3563);
        bx(0, 1, 0, 1, 32'h1234, 0, 0);
        chk("bcid_wrap", 32'(bcid0), 32'd0);

        // Reset while in deadtime holding an unread event.
        rr4 = 0;
        bx(1, 0, 1, 0, 32'hABCD, 0, 0);
        chk("busy4_pre", 32'(busy4), 32'd1);
        chk("valid4_pre", 32'(rv4), 32'd1);
        @(posedge clk);
        #1;
        rst = 1;
        q4.delete();
        q0.delete();
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("mid_l1a",   32'(l1a4),  32'd0);
        chk("mid_busy",  32'(busy4), 32'd0);
        chk("mid_valid", 32'(rv4),   32'd0);
        chk("mid_score", rs4,        32'd0);
        chk("mid_rbcid", 32'(rb4),   32'd0);
        chk("mid_bcid",  32'(bcid4), 32'd0);
        chk("mid_drop",  32'(dc4),   32'd0);
        cur_bcid = 0;
        rr4 = 1;
        bx(1, 0, 1, 0, 32'd77, 0, 0);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("q4_left", 32'(q4.size()), 32'd0);
        chk("q0_left", 32'(q0.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
